// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rstrb;
    logic [31:0]           i_rdata;
    logic                  i_done;

    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic [3:0]            d_wmask;
    logic                  d_rstrb;
    logic [31:0]           d_rdata;
    logic                  d_done;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wmask;
    logic                  mem_rstrb;
    logic [31:0]           mem_rdata;
    logic                  mem_done;

    // Arbiter side: serves the requesters, drives the memory controller.
    modport slave (
        input  i_addr, i_rstrb,
        output i_rdata, i_done,
        input  d_addr, d_wdata, d_wmask, d_rstrb,
        output d_rdata, d_done,
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata, mem_done
    );

    // Environment side: cache/core requesters plus memory controller.
    modport master (
        output i_addr, i_rstrb,
        input  i_rdata, i_done,
        output d_addr, d_wdata, d_wmask, d_rstrb,
        input  d_rdata, d_done,
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises I-cache fills and core data accesses onto one memory port
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties; otherwise the data port wins ties.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic                  rstrb_q, rstrb_d;
    logic [31:0]           i_rdata_q, i_rdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  grant_d_q, grant_d_d;

    logic req_i;
    logic req_d;
    logic tie_pick_d;
    logic pick_d;

    assign req_i = bus.i_rstrb;
    assign req_d = bus.d_rstrb | (|bus.d_wmask);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    assign tie_pick_d = ~last_d_q;
`else
    assign tie_pick_d = 1'b1;
`endif

    assign pick_d = req_d & (~req_i | tie_pick_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rstrb_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            grant_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rstrb_q   <= rstrb_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            grant_d_q <= grant_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rstrb_d   = rstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        grant_d_d = grant_d_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d  = last_d_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    grant_d_d = pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d  = pick_d;
`endif
                    if (pick_d) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        wmask_d = bus.d_wmask;
                        // A non-zero mask makes this a write; a simultaneous read strobe is dropped.
                        rstrb_d = (bus.d_wmask == 4'b0000);
                    end else begin
                        addr_d  = bus.i_addr;
                        wmask_d = 4'b0000;
                        rstrb_d = 1'b1;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_done) begin
                    rstrb_d = 1'b0;
                    wmask_d = 4'b0000;
                    if (grant_d_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_done_d  = 1'b1;
                    end
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_rstrb = rstrb_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;

endmodule
